// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory/writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    WAIT_MEM,
    READY
  } wb_state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Upstream instruction, data-memory response and register-file write bus.
interface mem_wb_stage_if #(
  parameter int N = 64
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_regwrite;
  logic         in_memtoreg;
  logic [4:0]   in_rd;
  logic [N-1:0] in_alu;
  logic         dm_rvalid;
  logic [N-1:0] dm_rdata;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;

  modport master (
    output flush, in_valid, in_regwrite, in_memtoreg, in_rd, in_alu,
    output dm_rvalid, dm_rdata,
    input  in_ready, we3, wa3, wd3
  );

  modport slave (
    input  flush, in_valid, in_regwrite, in_memtoreg, in_rd, in_alu,
    input  dm_rvalid, dm_rdata,
    output in_ready, we3, wa3, wd3
  );
endinterface

// File: rtl/mem_wb_stage_wait_timer.sv
// Load wait counter: cleared on load accept, reports the last allowed wait cycle.
module wb_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);
  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign done_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: holds one retiring instruction, waits for load data,
// and emits a single register-file write per committed instruction.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_wb_stage_if.slave    bus,
  output logic             err_timeout,
  output logic [CNT_W-1:0] load_stalls
);
  wb_state_t        state_q, state_d;
  logic             regwrite_q;
  logic [4:0]       rd_q;
  logic [N-1:0]     data_q;
  logic [4:0]       wa3_q;
  logic [N-1:0]     wd3_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stalls_q;
  logic             accept;
  logic             tmr_clr, tmr_inc, tmr_done;

  assign bus.in_ready = !bus.flush && (state_q == EMPTY || state_q == READY);
  assign accept       = bus.in_valid && bus.in_ready;

  wb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    tmr_inc = 1'b0;
    tmr_clr = accept && bus.in_memtoreg;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY, READY: begin
          if (accept) state_d = bus.in_memtoreg ? WAIT_MEM : READY;
          else        state_d = EMPTY;
        end
        WAIT_MEM: begin
          // Data arriving on the timeout cycle still wins over the abort.
          if (bus.dm_rvalid) begin
            state_d = READY;
          end else if (tmr_done) begin
            state_d = EMPTY;
            err_d   = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      err_q    <= 1'b0;
      stalls_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == WAIT_MEM && stalls_q != '1) stalls_q <= stalls_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else if (accept) begin
      regwrite_q <= bus.in_regwrite;
      rd_q       <= bus.in_rd;
      if (!bus.in_memtoreg) data_q <= bus.in_alu;
    end else if (state_q == WAIT_MEM && bus.dm_rvalid && !bus.flush) begin
      data_q <= bus.dm_rdata;
    end
  end

  // Outside READY the write port keeps presenting the last address/data it drove.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wa3_q <= '0;
      wd3_q <= '0;
    end else if (state_q == READY) begin
      wa3_q <= rd_q;
      wd3_q <= data_q;
    end
  end

  assign bus.we3   = (state_q == READY) && regwrite_q && (rd_q != XZR) && !bus.flush;
  assign bus.wa3   = (state_q == READY) ? rd_q : wa3_q;
  assign bus.wd3   = (state_q == READY) ? data_q : wd3_q;
  assign err_timeout = err_q;
  assign load_stalls = stalls_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus queues expected writes, a monitor retires them.
module tb_mem_wb_stage;
  import wb_pkg::*;

  localparam int N     = 64;
  localparam int CNT_W = 16;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             err_timeout;
  logic [CNT_W-1:0] load_stalls;
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;
  exp_t             expQ[$];

  mem_wb_stage_if #(.N(N)) bus ();

  mem_wb_stage #(.N(N), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .err_timeout (err_timeout),
    .load_stalls (load_stalls)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                               input logic [63:0] alu, input logic rv, input logic [63:0] rdata,
                               input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid    = v;
    bus.in_regwrite = rw;
    bus.in_memtoreg = m2r;
    bus.in_rd       = rd;
    bus.in_alu      = alu;
    bus.dm_rvalid   = rv;
    bus.dm_rdata    = rdata;
    bus.flush       = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic expectWrite(input int c, input logic [4:0] a, input logic [63:0] d);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    expQ.push_back(e);
  endtask

  // Every write the DUT emits must match the oldest queued expectation, cycle included.
  always @(negedge clk) begin
    if (bus.we3) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got wa3=%0d wd3=0x%0h, expected no write (cycle %0d)",
                 bus.wa3, bus.wd3, cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("write_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("wa3", 64'(bus.wa3), 64'(e.addr));
        checkOutput("wd3", bus.wd3, e.data);
      end
    end
  end

  initial begin
    int c;
    bus.in_valid = 0; bus.in_regwrite = 0; bus.in_memtoreg = 0; bus.in_rd = 0;
    bus.in_alu = 0; bus.dm_rvalid = 0; bus.dm_rdata = 0; bus.flush = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_we3", 64'(bus.we3), 64'd0);
    checkOutput("rst_wa3", 64'(bus.wa3), 64'd0);
    checkOutput("rst_wd3", bus.wd3, 64'd0);
    checkOutput("rst_err", 64'(err_timeout), 64'd0);
    checkOutput("rst_stalls", 64'(load_stalls), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1 reset = 1'b1;

    // Single ALU op.
    applyStimulus(1, 1, 0, 5'd5, 64'h2A, 0, 0, 0);
    expectWrite(cyc + 1, 5'd5, 64'h2A);
    idle(); idle();

    // Load answered three cycles after accept.
    applyStimulus(1, 1, 1, 5'd7, 64'h999, 0, 0, 0);
    c = cyc;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) applyStimulus(0, 0, 0, 0, 0, 1, 64'hDEAD, 0);
      else idle();
      @(negedge clk);
      checkOutput("load_in_ready_blocked", 64'(bus.in_ready), 64'd0);
    end
    expectWrite(c + 4, 5'd7, 64'hDEAD);
    idle();
    @(negedge clk);
    checkOutput("load_in_ready_back", 64'(bus.in_ready), 64'd1);
    checkOutput("load_stalls_3", 64'(load_stalls), 64'd3);

    // Back-to-back ALU ops, then XZR and regwrite=0 which must not write.
    applyStimulus(1, 1, 0, 5'd1, 64'h11, 0, 0, 0); expectWrite(cyc + 1, 5'd1, 64'h11);
    applyStimulus(1, 1, 0, 5'd2, 64'h22, 0, 0, 0); expectWrite(cyc + 1, 5'd2, 64'h22);
    applyStimulus(1, 1, 0, 5'd3, 64'h33, 0, 0, 0); expectWrite(cyc + 1, 5'd3, 64'h33);
    applyStimulus(1, 1, 0, XZR,  64'h44, 0, 0, 0);
    applyStimulus(1, 0, 0, 5'd4, 64'h55, 0, 0, 0);
    idle(); idle();

    // Timeout with no response; stray rvalid afterwards is ignored.
    applyStimulus(1, 1, 1, 5'd9, 0, 0, 0, 0);
    repeat (4) idle();
    @(negedge clk);
    checkOutput("to_err_not_yet", 64'(err_timeout), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 64'hBAD, 0);
    @(negedge clk);
    checkOutput("to_err_set", 64'(err_timeout), 64'd1);
    checkOutput("to_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("to_stalls_7", 64'(load_stalls), 64'd7);
    idle(); idle();
    @(negedge clk);
    checkOutput("to_err_sticky", 64'(err_timeout), 64'd1);

    // Reset, then response on the final allowed wait cycle.
    @(posedge clk); #1 reset = 1'b0;
    #2 checkOutput("to_err_cleared", 64'(err_timeout), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    applyStimulus(1, 1, 1, 5'd10, 0, 0, 0, 0);
    c = cyc;
    repeat (3) idle();
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h1234, 0);
    expectWrite(c + 5, 5'd10, 64'h1234);
    idle();
    @(negedge clk);
    checkOutput("late_err_clear", 64'(err_timeout), 64'd0);
    checkOutput("late_stalls_4", 64'(load_stalls), 64'd4);

    // Flush during WAIT_MEM, flush blocking accept, flush masking a READY write.
    applyStimulus(1, 1, 1, 5'd11, 0, 0, 0, 0);
    idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 64'hBEEF, 0);
    applyStimulus(1, 1, 0, 5'd12, 64'h55, 0, 0, 1);
    @(negedge clk);
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd0);
    idle();
    applyStimulus(1, 1, 0, 5'd13, 64'h66, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idle(); idle();

    // Asynchronous reset while a write is being presented.
    applyStimulus(1, 1, 0, 5'd14, 64'h77, 0, 0, 0);
    idle();
    #1 checkOutput("pre_reset_we3", 64'(bus.we3), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_we3", 64'(bus.we3), 64'd0);
    checkOutput("async_wa3", 64'(bus.wa3), 64'd0);
    checkOutput("async_wd3", bus.wd3, 64'd0);
    checkOutput("async_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("async_stalls", 64'(load_stalls), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    idle(); idle();
    @(negedge clk);

    checkOutput("pending_writes", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback pipeline stage that sits directly upstream of the register file's write port. It accepts one retiring instruction per cycle from the memory stage and waits, when needed, for a variable-latency data-memory load response. It then drives the register file's `we3`/`wa3`/`wd3` for exactly one cycle per committed instruction. Back-pressure goes upstream through `in_ready`, and a sticky error flags loads that time out.

## Interface
Parameters:
- `N`, 64: datapath width.
- `TIMEOUT`, 255: maximum cycles spent in WAIT_MEM before abort; must be ≥ 1.
- `CNT_W`, 16: width of the load-stall counter.

Ports:
- `clk`: in, 1. Single clock; all state updates on posedge.
- `reset`: in, 1. Asynchronous, active-low.
- `flush`: in, 1. Kills the held entry and blocks acceptance this cycle.
- `in_valid`: in, 1. Upstream has an instruction.
- `in_ready`: out, 1. Stage accepts this cycle.
- `in_regwrite`: in, 1. Instruction writes a register.
- `in_memtoreg`: in, 1. Result comes from a data-memory load.
- `in_rd`: in, 5. Destination register.
- `in_alu`: in, N. ALU result.
- `dm_rvalid`: in, 1. Load data valid.
- `dm_rdata`: in, N. Load data.
- `we3`: out, 1. Register-file write enable.
- `wa3`: out, 5. Register-file write address.
- `wd3`: out, N. Register-file write data.
- `err_timeout`: out, 1. Sticky; set when a load is aborted.
- `load_stalls`: out, CNT_W. Saturating count of cycles spent in WAIT_MEM.

## Operation
- States are EMPTY, WAIT_MEM and READY. Reset state is EMPTY. Held registers: `regwrite`, `rd`, `data`, and a wait counter.
- `in_ready` = !flush && (state==EMPTY || state==READY). An accept happens when `in_valid && in_ready`.
- On accept:
  - If `in_memtoreg` is 1: go to WAIT_MEM and clear the wait counter.
  - Otherwise: go to READY with `data` = `in_alu`.
  - In both cases latch `in_rd` and `in_regwrite`.
- WAIT_MEM:
  - If `dm_rvalid`: `data` ← `dm_rdata`, go to READY.
  - Else if the wait counter == TIMEOUT−1: set `err_timeout`, go to EMPTY, no write.
  - Else: increment the wait counter.
  - `load_stalls` increments every WAIT_MEM cycle and saturates at all-ones.
- READY:
  - `we3` = `regwrite` && (`rd` != XZR).
  - `wa3` = `rd`, `wd3` = `data`.
  - Next state comes from the accept rule if an accept occurs, otherwise EMPTY.
- When not in READY, `we3` = 0, and `wa3`/`wd3` hold their last values.
- Writes to XZR (register 31) are never emitted.
- `dm_rvalid` outside WAIT_MEM is ignored.
- `flush` has top priority. Any state goes to EMPTY and no `we3` is emitted that cycle. `err_timeout` and `load_stalls` are unaffected.
- If `dm_rvalid` arrives in the same cycle as the timeout, the data wins: go to READY, no error.
- `err_timeout` clears only on reset.

## Timing
- Reset (asynchronous, `reset`==0):
  - state EMPTY.
  - `we3`=0, `wa3`=0, `wd3`=0.
  - `err_timeout`=0, `load_stalls`=0.
  - `in_ready`=1 (unless `flush` is high).
- ALU instruction accepted in cycle N: `we3` is high in cycle N+1.
- Load accepted in cycle N, `dm_rvalid` in cycle M ≥ N+1: `we3` is high in cycle M+1.
- Throughput: back-to-back ALU instructions retire one per cycle with no bubbles.
- A load blocks `in_ready` from cycle N+1 through cycle M inclusive.
- Timeout: with no response, abort occurs on the TIMEOUT-th WAIT_MEM cycle, and `err_timeout` is visible the following cycle.
- Reset asserted mid-operation drops the held entry immediately; no write is issued.

## Structure
- Package `wb_pkg` holds:
  - `wb_state_t` enum (EMPTY, WAIT_MEM, READY).
  - `XZR` = 5'd31.
- Sub-module `wb_wait_timer` holds the clear/increment/terminal-count wait counter, parameterised by TIMEOUT.
- The saturating `load_stalls` counter stays inline.

## Test plan
- ALU op in cycle 1 (rd=5, alu=0x2A, regwrite=1) → cycle 2: `we3`=1, `wa3`=5, `wd3`=0x2A; cycle 3: `we3`=0.
- Load in cycle 1 (rd=7), `dm_rvalid` with 0xDEAD in cycle 4 → `in_ready`=0 in cycles 2–4; `we3`=1, `wa3`=7, `wd3`=0xDEAD in cycle 5; `load_stalls`=3.
- Three consecutive ALU ops (rd=1,2,3) → `we3` high in three consecutive cycles with matching `wa3`; an op with rd=31 or regwrite=0 → `we3` stays 0.
- TIMEOUT=4, load with no response → abort after 4 WAIT_MEM cycles; `err_timeout`=1 and sticky; no write; `in_ready` returns to 1. A repeat run with `dm_rvalid` on the 4th cycle → write, `err_timeout`=0.
- `flush` while in WAIT_MEM, then `dm_rvalid` next cycle → no `we3`; `flush` with `in_valid` high → `in_ready`=0, instruction not taken.
- `reset` pulled low asynchronously while in READY → `we3` drops to 0 immediately; all outputs at reset values.
